// File: rtl/mlp_pkg.sv
// Shared constants and state encoding for the MLP output-layer sequencer.
package mlp_pkg;

  // Q1.15 datapath
  localparam int DW        = 16;
  localparam int FRAC      = 15;

  // Network shape
  localparam int N_HID     = 8;
  localparam int AW        = 3;
  localparam int N_OUT_DEF = 4;

  // State encoding
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE = S_IDLE,
    ST_RUN  = S_RUN,
    ST_DONE = S_DONE
  } seq_state_e;

  // True when addr points at the last output neuron of an n-neuron layer.
  function automatic logic is_last(input logic [AW-1:0] addr, input int n);
    return addr == AW'(n - 1);
  endfunction

endpackage

// File: rtl/mlp_output_sequencer_argmax_track.sv
// Registered running-maximum tracker. Strict greater-than keeps the lowest
// index on equal values. nxt_* expose the value the registers take on the
// coming edge so a caller can publish the final result on the same edge.
module argmax_track #(
  parameter int DW = 16,
  parameter int AW = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear_i,
  input  logic          valid_i,
  input  logic [DW-1:0] value_i,
  input  logic [AW-1:0] index_i,
  output logic [DW-1:0] best_val_o,
  output logic [AW-1:0] best_idx_o,
  output logic [DW-1:0] nxt_val_o,
  output logic [AW-1:0] nxt_idx_o
);

  logic [DW-1:0] best_val_q, best_val_d;
  logic [AW-1:0] best_idx_q, best_idx_d;

  // Next best: clear has priority, otherwise take a strictly larger sample.
  always_comb begin
    best_val_d = best_val_q;
    best_idx_d = best_idx_q;
    if (clear_i) begin
      best_val_d = '0;
      best_idx_d = '0;
    end else if (valid_i && ($signed(value_i) > $signed(best_val_q))) begin
      best_val_d = value_i;
      best_idx_d = index_i;
    end
  end

  // Best-so-far registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      best_val_q <= '0;
      best_idx_q <= '0;
    end else begin
      best_val_q <= best_val_d;
      best_idx_q <= best_idx_d;
    end
  end

  assign best_val_o = best_val_q;
  assign best_idx_o = best_idx_q;
  assign nxt_val_o  = best_val_d;
  assign nxt_idx_o  = best_idx_d;

endmodule

// File: rtl/mlp_output_sequencer.sv
// Output-layer sequencer: latches the hidden vector on start, walks the
// shared neuron through every output address, captures each score and
// reports the argmax class with a one-cycle done pulse.
//
//   state | meaning
//   IDLE  | waiting for start; all results held
//   RUN   | one neuron address per cycle, scores captured
//   DONE  | done pulse, class_idx/class_score valid
module mlp_output_sequencer
  import mlp_pkg::*;
#(
  parameter int N_OUT = N_OUT_DEF,
  parameter int DW    = mlp_pkg::DW,
  parameter int AW    = mlp_pkg::AW
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [N_HID*DW-1:0]  hidden_in,
  output logic [N_HID*DW-1:0]  hid_q,
  output logic [AW-1:0]        nrn_addr,
  input  logic [DW-1:0]        nrn_out,
  output logic                 busy,
  output logic                 done,
  output logic [AW-1:0]        class_idx,
  output logic [DW-1:0]        class_score,
  output logic [N_OUT*DW-1:0]  scores
);

  seq_state_e           state_q, state_d;
  logic [N_HID*DW-1:0]  hid_lat_q, hid_lat_d;
  logic [AW-1:0]        addr_q, addr_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic [AW-1:0]        cls_idx_q, cls_idx_d;
  logic [DW-1:0]        cls_score_q, cls_score_d;
  logic [N_OUT*DW-1:0]  scores_q, scores_d;

  logic                 trk_clear;
  logic                 trk_valid;
  logic [DW-1:0]        best_val;
  logic [AW-1:0]        best_idx;
  logic [DW-1:0]        nxt_val;
  logic [AW-1:0]        nxt_idx;

  argmax_track #(
    .DW (DW),
    .AW (AW)
  ) u_argmax (
    .clk        (clk),
    .rst        (rst),
    .clear_i    (trk_clear),
    .valid_i    (trk_valid),
    .value_i    (nrn_out),
    .index_i    (addr_q),
    .best_val_o (best_val),
    .best_idx_o (best_idx),
    .nxt_val_o  (nxt_val),
    .nxt_idx_o  (nxt_idx)
  );

  // Next-state and datapath control; the result registers load from the
  // tracker's next value so the last neuron is included on the DONE entry edge.
  always_comb begin
    state_d     = state_q;
    hid_lat_d   = hid_lat_q;
    addr_d      = addr_q;
    done_d      = 1'b0;
    cls_idx_d   = cls_idx_q;
    cls_score_d = cls_score_q;
    scores_d    = scores_q;
    trk_clear   = 1'b0;
    trk_valid   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          hid_lat_d = hidden_in;
          addr_d    = '0;
          trk_clear = 1'b1;
          state_d   = ST_RUN;
        end
      end
      ST_RUN: begin
        trk_valid = 1'b1;
        for (int k = 0; k < N_OUT; k++) begin
          if (addr_q == AW'(k)) begin
            scores_d[k*DW +: DW] = nrn_out;
          end
        end
        if (is_last(addr_q, N_OUT)) begin
          state_d     = ST_DONE;
          done_d      = 1'b1;
          cls_idx_d   = nxt_idx;
          cls_score_d = nxt_val;
        end else begin
          addr_d = addr_q + AW'(1);
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d == ST_RUN) || (state_d == ST_DONE);
  end

  // State and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      hid_lat_q   <= '0;
      addr_q      <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      cls_idx_q   <= '0;
      cls_score_q <= '0;
      scores_q    <= '0;
    end else begin
      state_q     <= state_d;
      hid_lat_q   <= hid_lat_d;
      addr_q      <= addr_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      cls_idx_q   <= cls_idx_d;
      cls_score_q <= cls_score_d;
      scores_q    <= scores_d;
    end
  end

  assign hid_q       = hid_lat_q;
  assign nrn_addr    = addr_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign class_idx   = cls_idx_q;
  assign class_score = cls_score_q;
  assign scores      = scores_q;

  // The tracker's registered outputs are observable state but not routed out.
  logic unused_best;
  assign unused_best = ^{best_val, best_idx};

endmodule

// File: tb/tb_mlp_output_sequencer.sv
// Bench for mlp_output_sequencer: a behavioural neuron (score = hidden word
// at the addressed position, forced non-negative), a queue of expected
// results filled at launch, and a monitor that checks every done pulse.
module tb_mlp_output_sequencer;

  localparam int N_OUT = 4;
  localparam int DW    = 16;
  localparam int AW    = 3;
  localparam int HW    = 8 * DW;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [HW-1:0]     hidden_in;
  logic [HW-1:0]     hid_q;
  logic [AW-1:0]     nrn_addr;
  logic [DW-1:0]     nrn_out;
  logic              busy;
  logic              done;
  logic [AW-1:0]     class_idx;
  logic [DW-1:0]     class_score;
  logic [N_OUT*DW-1:0] scores;

  mlp_output_sequencer #(.N_OUT(N_OUT), .DW(DW), .AW(AW)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .hidden_in   (hidden_in),
    .hid_q       (hid_q),
    .nrn_addr    (nrn_addr),
    .nrn_out     (nrn_out),
    .busy        (busy),
    .done        (done),
    .class_idx   (class_idx),
    .class_score (class_score),
    .scores      (scores)
  );

  always #5 clk = ~clk;

  // Behavioural neuron: ReLU-style non-negative score from the latched vector.
  assign nrn_out = hid_q[nrn_addr*DW +: DW] & 16'h7FFF;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [HW-1:0]       hv;
    logic [AW-1:0]       idx;
    logic [DW-1:0]       score;
    logic [N_OUT*DW-1:0] sc;
    int                  done_cyc;
  } exp_t;

  exp_t exp_q[$];
  int   errs   = 0;
  int   checks = 0;

  task automatic chk(input string name, input logic [HW-1:0] act, input logic [HW-1:0] req);
    checks++;
    if (act !== req) begin
      errs++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Reference: scores are the masked hidden words; winner is the first
  // occurrence of the maximum (zero when everything is zero).
  function automatic exp_t model(input logic [HW-1:0] hv);
    exp_t e;
    logic [DW-1:0] s;
    e.hv = hv; e.idx = '0; e.score = '0; e.sc = '0; e.done_cyc = 0;
    for (int k = 0; k < N_OUT; k++) begin
      s = hv[k*DW +: DW] & 16'h7FFF;
      e.sc[k*DW +: DW] = s;
      if (s > e.score) begin
        e.score = s;
        e.idx   = AW'(k);
      end
    end
    return e;
  endfunction

  function automatic logic [HW-1:0] mk_hv(input logic [DW-1:0] s0, s1, s2, s3);
    logic [HW-1:0] v;
    v = {$urandom, $urandom, $urandom, $urandom};
    v[0*DW +: DW] = s0;
    v[1*DW +: DW] = s1;
    v[2*DW +: DW] = s2;
    v[3*DW +: DW] = s3;
    return v;
  endfunction

  // Monitor: every done pulse must match the oldest outstanding launch.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && done) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk("class_idx", HW'(class_idx), HW'(e.idx));
          chk("class_score", HW'(class_score), HW'(e.score));
          chk("scores", HW'(scores), HW'(e.sc));
          chk("hid_q_at_done", hid_q, e.hv);
          chk("done_latency", HW'(cyc), HW'(e.done_cyc));
        end
      end
    end
  end

  // Called just after a posedge with the DUT idle; returns just after the start edge.
  task automatic launch(input logic [HW-1:0] hv);
    exp_t e;
    e = model(hv);
    e.done_cyc = cyc + 5;
    hidden_in = hv;
    start = 1'b1;
    exp_q.push_back(e);
    @(negedge clk);
    chk("busy_before_start", HW'(busy), 0);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Waits for done with a cycle budget; optionally disturbs inputs while busy.
  task automatic finish_run(input bit scramble, input bit extra_start, input bit addr_chk);
    bit seen = 0;
    int nbusy = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (busy) nbusy++;
      if (addr_chk) chk("nrn_addr_step", HW'(nrn_addr), HW'((i < 3) ? i : 3));
      if (done) seen = 1;
      if (!seen) begin
        @(posedge clk); #1;
        if (scramble)    hidden_in = {$urandom, $urandom, $urandom, $urandom};
        if (extra_start) start = 1'($urandom_range(0, 1));
      end
    end
    if (!seen) chk("done_timeout", 0, 1);
    chk("busy_cycles", HW'(nbusy), 5);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  initial begin
    logic [DW-1:0] pick [5];
    logic [DW-1:0] v [4];
    rst = 1'b1; start = 1'b0; hidden_in = '0;
    repeat (3) @(posedge clk);
    #1 hidden_in = {$urandom, $urandom, $urandom, $urandom};
    @(negedge clk);
    chk("rst_busy", HW'(busy), 0);
    chk("rst_done", HW'(done), 0);
    chk("rst_hid_q", hid_q, 0);
    chk("rst_addr", HW'(nrn_addr), 0);
    chk("rst_class", HW'({class_idx, class_score}), 0);
    chk("rst_scores", HW'(scores), 0);
    @(posedge clk); #1 rst = 1'b0;

    // Basic run with address stepping
    launch(mk_hv(16'h1000, 16'h3000, 16'h0800, 16'h2000));
    finish_run(0, 0, 1);
    // Tie: lowest index wins
    launch(mk_hv(16'h2000, 16'h4000, 16'h4000, 16'h0000));
    finish_run(0, 0, 0);
    // All clamped to zero (0x8000 masks to zero)
    launch(mk_hv(16'h0000, 16'h8000, 16'h0000, 16'h8000));
    finish_run(0, 0, 0);
    // Input isolation and ignored restarts
    launch(mk_hv(16'h0123, 16'h0456, 16'h6789, 16'h0ABC));
    finish_run(1, 1, 1);

    // Reset while nrn_addr == 2
    launch(mk_hv(16'h1111, 16'h2222, 16'h3333, 16'h4444));
    repeat (2) begin @(negedge clk); @(posedge clk); #1; end
    @(negedge clk);
    chk("addr_before_rst", HW'(nrn_addr), 2);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_q.delete();
    @(negedge clk);
    chk("midrst_busy", HW'(busy), 0);
    chk("midrst_done", HW'(done), 0);
    chk("midrst_scores", HW'(scores), 0);
    chk("midrst_class", HW'({class_idx, class_score}), 0);
    chk("midrst_addr", HW'(nrn_addr), 0);
    repeat (3) begin
      @(negedge clk);
      chk("midrst_idle", HW'({busy, done}), 0);
    end
    @(posedge clk); #1;

    // Fresh start, then back-to-back run with the winner at the last index
    launch(mk_hv(16'h7000, 16'h0100, 16'h0200, 16'h0300));
    finish_run(0, 0, 0);
    launch(mk_hv(16'h0000, 16'h0000, 16'h0000, 16'h7FFF));
    finish_run(0, 0, 1);

    // Randomized runs; values drawn from a small pool so ties occur often
    for (int r = 0; r < 30; r++) begin
      pick[0] = 16'h0000; pick[1] = 16'h1000; pick[2] = 16'h4000;
      pick[3] = 16'h7FFF; pick[4] = 16'($urandom);
      for (int k = 0; k < 4; k++) v[k] = pick[$urandom_range(0, 4)];
      if ($urandom_range(0, 1) == 1) begin
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
      end
      launch(mk_hv(v[0], v[1], v[2], v[3]));
      finish_run(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    repeat (3) @(negedge clk);
    chk("queue_drained", HW'(exp_q.size()), 0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/mlp_output_sequencer.md
Name: mlp_output_sequencer

Overview:
- Sequencer for the shared output-layer neuron datapath (`neuron_o`: 8 Q1.15 hidden inputs, 3-bit ROM address, combinational ReLU Q1.15 output).
- On `start`, latches the hidden-layer vector and steps `nrn_addr` through every output neuron, one per cycle.
- Captures each score, tracks a running argmax, and reports the winning class with a one-cycle `done` pulse.
- Sits between the hidden-layer stage and the classifier result/UART logic.

Parameters:
- N_OUT, 4, number of output neurons / classes; legal range 2..8.
- DW, 16, datapath word width (Q1.15).
- AW, 3, neuron ROM address width.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  launch request; sampled only in IDLE.
- hidden_in  in  8*DW  hidden outputs h1..h8; h1 in bits [15:0], h8 in [127:112].
- hid_q  out  8*DW  latched hidden vector driven to the neuron h1..h8 inputs.
- nrn_addr  out  AW  registered address driven to the neuron addr input.
- nrn_out  in  DW  neuron result; combinational from `hid_q`/`nrn_addr`, non-negative.
- busy  out  1  high in RUN and DONE.
- done  out  1  single-cycle pulse in DONE.
- class_idx  out  AW  argmax index, held until next `done`.
- class_score  out  DW  winning score, held until next `done`.
- scores  out  N_OUT*DW  all captured scores; class k in bits [k*DW +: DW].

Behaviour:
- States: IDLE, RUN, DONE. Encoding is free.
- Reset (synchronous) values:
  - state=IDLE; `hid_q`=0; `nrn_addr`=0; `busy`=0; `done`=0.
  - `class_idx`=0; `class_score`=0; `scores`=0; internal best regs=0.
- IDLE, `start`=1 at edge T:
  - `hid_q` <= `hidden_in`; `nrn_addr` <= 0.
  - best_score <= 0; best_idx <= 0; state <= RUN.
- IDLE, `start`=0: all regs hold.
- RUN, each edge:
  - scores[nrn_addr] <= `nrn_out`.
  - If `nrn_out` > best_score (strict, signed compare): best_score <= `nrn_out`, best_idx <= `nrn_addr`.
  - If `nrn_addr` == N_OUT-1: state <= DONE and `nrn_addr` holds. Otherwise `nrn_addr` <= `nrn_addr`+1.
- Tie-break rule: strict compare means the lowest index wins on equal scores.
- All-zero outputs (every neuron clamped by ReLU): class_idx=0, class_score=0.
- DONE, one cycle:
  - `done`=1.
  - `class_idx`/`class_score` updated from best regs on the DONE entry edge, so they are valid while `done`=1.
  - Next edge: state <= IDLE.
- Latency: `start` sampled at edge T; RUN occupies edges T+1..T+N_OUT; `done` high during cycle T+N_OUT+1 (T+5 for N_OUT=4).
- `start` in RUN or DONE is ignored, not queued. Back-to-back runs: `start` may be re-asserted in the cycle after `done`.
- `hidden_in` may change freely after the start edge; `hid_q` isolates the datapath.
- `rst` mid-run returns to IDLE next edge:
  - `done` is not emitted.
  - `scores`, `class_idx` and `class_score` are cleared to 0.
- Arithmetic: compare only, no adders beyond the address counter; `nrn_out` is treated as signed DW.
- `busy` is registered: `busy`=1 exactly when state is RUN or DONE.

Decomposition:
- Shared package `mlp_pkg` holds:
  - Q-format constants: DW=16, FRAC=15.
  - Hidden count N_HID=8, AW=3, default N_OUT.
  - State encoding localparams for IDLE/RUN/DONE.
- The neuron datapath stays external and is instantiated beside this block by the parent, so the sequencer can be verified against a behavioural score model.
- Optional sub-module `argmax_track`: a registered running-maximum tracker (clear, valid, value, index → best_val, best_idx) with strict greater-than compare.

Test Plan:
- Basic run: N_OUT=4, bench model nrn_out = {0x1000, 0x3000, 0x0800, 0x2000} by addr; pulse `start` → `nrn_addr` steps 0,1,2,3; `done` 5 cycles after start; class_idx=1, class_score=0x3000, scores match.
- Tie: scores {0x2000, 0x4000, 0x4000, 0x0000} → class_idx=1, class_score=0x4000.
- All ReLU-zero: scores all 0 → class_idx=0, class_score=0, `done` still pulses once.
- Input isolation and busy behaviour:
  - Change `hidden_in` every cycle after `start` → `hid_q` stays at the value captured on the start edge.
  - A second `start` during RUN is ignored: exactly one `done`, `busy` stays high for 5 cycles.
- Reset mid-run: assert `rst` while `nrn_addr`=2 → next cycle state IDLE, `busy`=0, `scores`=0, no `done`; a fresh `start` completes normally.
- Back-to-back: `start` in the cycle after `done`, with scores {0,0,0,0x7FFF} → class_idx=3, class_score=0x7FFF, no stale best from the prior run.
